// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and op-classification helpers for the execute unit.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] op_t;

  // ALU control codes, shared with the decode-stage ALU decoder
  localparam op_t OP_ADD  = 4'b0000;
  localparam op_t OP_SUB  = 4'b0001;
  localparam op_t OP_AND  = 4'b0010;
  localparam op_t OP_OR   = 4'b0011;
  localparam op_t OP_SLTU = 4'b0100;
  localparam op_t OP_SLT  = 4'b0101;
  localparam op_t OP_XOR  = 4'b0110;
  localparam op_t OP_SLL  = 4'b0111;
  localparam op_t OP_SRL  = 4'b1000;
  localparam op_t OP_SRA  = 4'b1001;
  localparam op_t OP_BEQ  = 4'b1010;
  localparam op_t OP_BNE  = 4'b1011;
  localparam op_t OP_BLT  = 4'b1100;
  localparam op_t OP_BGE  = 4'b1101;
  localparam op_t OP_BLTU = 4'b1110;
  localparam op_t OP_BGEU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_e;

  // True for the serial (multi-cycle) shift ops
  function automatic logic is_shift(input op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // True for the conditional-branch ops (the top six codes)
  function automatic logic is_branch(input op_t op);
    return op >= OP_BEQ;
  endfunction

  // Map a shift op code onto the shifter direction/fill control
  function automatic shift_kind_e shift_kind(input op_t op);
    shift_kind_e k;
    case (op)
      OP_SRL:  k = SH_SRL;
      OP_SRA:  k = SH_SRA;
      default: k = SH_SLL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle shifter: loads an operand and a shift count, then shifts
// once per clock until the count runs out. done_c_o flags the final step so the
// caller can capture data_c_o (the value after that step) on the same edge.
module serial_shifter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  shift_kind_e              kind_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [$clog2(XLEN)-1:0]  shamt_i,
  output logic                     done_c_o,
  output logic [XLEN-1:0]          data_c_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  shift_kind_e     kind_q, kind_d;
  logic [XLEN-1:0] shifted;

  // Single-bit shift of the working register; sra replicates the sign bit,
  // which is always the original operand's MSB
  always_comb begin
    shifted = shreg_q;
    case (kind_q)
      SH_SLL:  shifted = {shreg_q[XLEN-2:0], 1'b0};
      SH_SRL:  shifted = {1'b0, shreg_q[XLEN-1:1]};
      SH_SRA:  shifted = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
      default: shifted = shreg_q;
    endcase
  end

  // Load / step / clear control for the working register and down-counter
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      shreg_d = data_i;
      cnt_d   = shamt_i;
      kind_d  = kind_i;
    end else if (cnt_q != '0) begin
      shreg_d = shifted;
      cnt_d   = cnt_q - SHW'(1);
    end
  end

  // Shifter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      kind_q  <= SH_SLL;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  assign done_c_o = (cnt_q == SHW'(1));
  assign data_c_o = shifted;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle add/logic/compare/branch ops and serial shifts,
// with a valid/ready handshake on both sides and a hazard-unit flush.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            taken_q, taken_d;
  logic            valid_q, valid_d;

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sum, diff;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] alu_res;
  logic            alu_taken;

  logic            sh_start, sh_clear, sh_done_c;
  logic [XLEN-1:0] sh_data_c;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = src_b[SHW-1:0];

  // Shared adder/subtractor and comparators
  always_comb begin
    sum  = src_a + src_b;
    diff = src_a - src_b;
    lt_s = $signed(src_a) < $signed(src_b);
    lt_u = src_a < src_b;
    eq   = src_a == src_b;
  end

  // Single-cycle result and branch decision; branches return the wrapped sum
  always_comb begin
    alu_res   = sum;
    alu_taken = 1'b0;
    case (alu_ctrl)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLTU: alu_res = XLEN'(lt_u);
      OP_SLT:  alu_res = XLEN'(lt_s);
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_BEQ:  alu_taken = eq;
      OP_BNE:  alu_taken = !eq;
      OP_BLT:  alu_taken = lt_s;
      OP_BGE:  alu_taken = !lt_s;
      OP_BLTU: alu_taken = lt_u;
      OP_BGEU: alu_taken = !lt_u;
      default: alu_res = sum;
    endcase
    if (!is_branch(alu_ctrl)) alu_taken = 1'b0;
  end

  serial_shifter #(
    .XLEN (XLEN)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (sh_start),
    .clear_i  (sh_clear),
    .kind_i   (shift_kind(alu_ctrl)),
    .data_i   (src_a),
    .shamt_i  (shamt),
    .done_c_o (sh_done_c),
    .data_c_o (sh_data_c)
  );

  // Next-state and output-register logic; flush overrides any transfer
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    taken_d  = taken_q;
    valid_d  = valid_q;
    sh_start = 1'b0;
    sh_clear = 1'b0;
    if (flush) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      sh_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if ((state_q == ST_DONE) && out_ready) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
          if (accept) begin
            if (is_shift(alu_ctrl)) begin
              taken_d = 1'b0;
              if (shamt == '0) begin
                result_d = src_a;
                state_d  = ST_DONE;
                valid_d  = 1'b1;
              end else begin
                sh_start = 1'b1;
                state_d  = ST_SHIFT;
                valid_d  = 1'b0;
              end
            end else begin
              result_d = alu_res;
              taken_d  = alu_taken;
              state_d  = ST_DONE;
              valid_d  = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_done_c) begin
            result_d = sh_data_c;
            state_d  = ST_DONE;
            valid_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      taken_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      taken_q  <= taken_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid    = valid_q;
  assign result       = result_q;
  assign branch_taken = taken_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a vector table for single-cycle ops plus
// hand-written sequences for shifts, backpressure, flush and mid-shift reset.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_ctrl     (alu_ctrl),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        tk;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
  endtask

  // Issue a shift from IDLE and measure cycles until out_valid
  task automatic run_shift(input string nm, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    logic rdy_seen;
    offer(op, a, b);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 1;
    rdy_seen = 1'b0;
    while (!out_valid && k < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      k++;
    end
    check({nm, " latency"}, 32'(k), 32'(lat));
    check({nm, " result"}, result, exp);
    check({nm, " taken"}, 32'(branch_taken), 32'd0);
    check({nm, " in_ready low while shifting"}, 32'(rdy_seen), 32'd0);
    tick();
    check({nm, " back to idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int guard;
    logic seen;

    vecs[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[1]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[3]  = '{OP_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[4]  = '{OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
    vecs[5]  = '{OP_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0};
    vecs[6]  = '{OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0};
    vecs[7]  = '{OP_BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[8]  = '{OP_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[9]  = '{OP_BEQ,  32'h0000_0007, 32'h0000_0007, 32'h0000_000E, 1'b1};
    vecs[10] = '{OP_BNE,  32'h0000_0007, 32'h0000_0007, 32'h0000_000E, 1'b0};
    vecs[11] = '{OP_BGE,  32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b1};
    vecs[12] = '{OP_BGEU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[13] = '{OP_ADD,  32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0};
    vecs[14] = '{OP_SLTU, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b0};
    vecs[15] = '{OP_SLT,  32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'd0;
    src_a     = '0;
    src_b     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset taken", 32'(branch_taken), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Back-to-back single-cycle ops: one result per cycle, latency 1
    for (int i = 0; i < 16; i++) begin
      offer(vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check($sformatf("vec%0d taken", i), 32'(branch_taken), 32'(vecs[i].tk));
    end
    in_valid = 1'b0;
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Serial shifts
    run_shift("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run_shift("srl31", OP_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_shift("sll0", OP_SLL, 32'h1234_ABCD, 32'd0, 32'h1234_ABCD, 1);
    run_shift("sll4 upper b ignored", OP_SLL, 32'h0000_0001, 32'hFFFF_FF24, 32'h0000_0010, 5);
    run_shift("sra4 neg", OP_SRA, 32'h8000_0010, 32'd4, 32'hF800_0001, 5);
    run_shift("srl4", OP_SRL, 32'h8000_0010, 32'd4, 32'h0800_0001, 5);
    run_shift("sra4 pos", OP_SRA, 32'h7000_0000, 32'd4, 32'h0700_0000, 5);

    // Backpressure: xor result held for 10 cycles with in_ready low
    out_ready = 1'b0;
    offer(OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d result", i), result, 32'hAAAA_AAAA);
      check($sformatf("hold%0d taken", i), 32'(branch_taken), 32'd0);
      check($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
      tick();
    end
    offer(OP_ADD, 32'd1, 32'd2);
    out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("release out_valid", 32'(out_valid), 32'd1);
    check("release result", result, 32'd3);
    tick();
    check("release drain", 32'(out_valid), 32'd0);

    // Flush during SHIFT with a concurrent offer
    offer(OP_SLL, 32'h0000_0001, 32'd15);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    offer(OP_ADD, 32'd100, 32'd200);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready idle", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush no late valid", 32'(seen), 32'd0);
    offer(OP_ADD, 32'd5, 32'd6);
    tick();
    in_valid = 1'b0;
    check("post-flush add valid", 32'(out_valid), 32'd1);
    check("post-flush add result", result, 32'd11);
    tick();

    // Flush wins over a transfer offered from IDLE
    offer(OP_ADD, 32'd9, 32'd9);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush idle discard", 32'(out_valid), 32'd0);
    tick();
    check("flush idle still empty", 32'(out_valid), 32'd0);

    // Reset mid-shift after a taken branch left non-zero outputs
    offer(OP_BEQ, 32'd7, 32'd7);
    tick();
    in_valid = 1'b0;
    check("pre-reset beq result", result, 32'd14);
    check("pre-reset beq taken", 32'(branch_taken), 32'd1);
    tick();
    offer(OP_SLL, 32'h0000_0001, 32'd20);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mid-shift reset out_valid", 32'(out_valid), 32'd0);
    check("mid-shift reset result", result, 32'd0);
    check("mid-shift reset taken", 32'(branch_taken), 32'd0);
    check("mid-shift reset in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    guard = 0;
    seen = 1'b0;
    while (guard < 25) begin
      if (out_valid) seen = 1'b1;
      tick();
      guard++;
    end
    check("post-reset no stale shift", 32'(seen), 32'd0);
    offer(OP_SUB, 32'd10, 32'd3);
    tick();
    in_valid = 1'b0;
    check("post-reset sub result", result, 32'd7);
    check("post-reset sub valid", 32'(out_valid), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
